ifetch: RTL and testbench
=========================

// Module: ifetch
// PURPOSE
// - Instruction fetch stage; sits directly upstream of the next-IP logic (ip_comb).
// - Owns the IP register, drives the sync-read instruction memory and presents {IP, instruction} to decode.
// - Takes the next IP back from ip_comb (ip_result). Adds decode backpressure, halt/resume and external vector entry.
// PARAMETERS
// - IADDR_WIDTH   10          instruction address width, must match ip_comb iaddr_width
// - INSTR_WIDTH   16          instruction word width
// - RESET_VECTOR  0           IP loaded on reset
// PORTS
// - clk          in   1            single clock, all logic on rising edge
// - rst          in   1            synchronous, active-high reset
// - ip           out  IADDR_WIDTH  current IP, feeds ip_comb IP input
// - ip_next      in   IADDR_WIDTH  ip_comb ip_result, sequential/branch target
// - imem_addr    out  IADDR_WIDTH  instruction memory read address (combinational)
// - imem_en      out  1            memory read enable; data valid next cycle, held while 0
// - imem_rdata   in   INSTR_WIDTH  memory read data
// - instr        out  INSTR_WIDTH  instruction at ip, = imem_rdata
// - instr_valid  out  1            instr/ip valid for decode
// - instr_ready  in   1            decode accepts (retires) instr this cycle
// - halt_req     in   1            level; stop fetching at next instruction boundary
// - halted       out  1            high in HALT state
// - vec_valid    in   1            level; request entry to vec_addr at next boundary
// - vec_addr     in   IADDR_WIDTH  vector target
// - vec_ack      out  1            1-cycle pulse when vector taken
// - vec_ret      out  IADDR_WIDTH  return address (= ip_next) qualified by vec_ack
// - perf_retired out  32           retired instruction count (see CONFIGURATION)
// - perf_stall   out  32           cycles with instr_valid && !instr_ready
// BEHAVIOUR
// - States FILL, RUN, HALT. Reset: ip=RESET_VECTOR, state=FILL; instr_valid/halted/vec_ack=0; perf=0.
// - accept = instr_valid && instr_ready. target = vec_valid ? vec_addr : ip_next.
// - FILL: imem_en=1, imem_addr=ip, instr_valid=0; next RUN. One bubble after reset/resume.
// - RUN: instr_valid=1. On accept: ip<=target, imem_addr=target, vec_ack=vec_valid, vec_ret=ip_next.
//   imem_en=1 unless halt_req. Branches/vectors have zero bubbles: ip_next is combinational from ip.
// - RUN and !instr_ready: imem_en=0, imem_addr=ip, ip/instr held, vec/halt deferred.
// - RUN, accept && halt_req: ip<=target, imem_en=0, next HALT (a pending vector is still taken).
// - HALT: instr_valid=0, halted=1, imem_en=0, vec_valid ignored; !halt_req -> FILL.
// - halt_req/vec_valid act only on accept; never mid-instruction.
// - IP arithmetic mod 2^IADDR_WIDTH; wrap is the ip_comb result, no special case here.
// - rst overrides every state incl. a stalled RUN; it takes effect next cycle and drops any in-flight read.
// CONFIGURATION
// - IFETCH_PERF_EN defined: perf_retired += accept and perf_stall += stall, both wrap at 2^32, cleared by rst.
// - Not defined: perf_retired/perf_stall tied to 0, no counter flops.
// STRUCTURE
// - ifetch_pkg: state enum (FILL/RUN/HALT), default RESET_VECTOR constant.
// - Sub-module ifetch_perf: the two counters, instantiated only under IFETCH_PERF_EN.
// TESTING
// - Reset, sequential ip_next=ip+1, ready=1 -> cycle1 FILL addr 0; valid from cycle2; ip 0,1,2 one per cycle.
// - At ip=5, ip_next=0x3F0, ready=1 -> next cycle ip=0x3F0, instr=mem[0x3F0], no bubble.
// - ip=7, ready=0 for 3 cycles -> imem_en=0, ip=7, instr stable, perf_stall+=3; then ready=1 -> ip=8.
// - halt_req at accept of ip=4 -> halted, valid=0, ip=5. Release -> FILL, then instr at 5 valid.
// - vec_valid, vec_addr=0x200 at accept of ip=9 (ip_next=10) -> vec_ack pulse, vec_ret=10, ip=0x200.
// - rst during stall at ip=0x3FF -> ip=0, FILL, valid=0, perf counters 0. Wrap: ip_next 0 after 0x3FF.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg
// Shared definitions for the instruction fetch stage:
//   state_e              fetch FSM state encoding (FILL / RUN / HALT)
//   DEFAULT_RESET_VECTOR IP loaded on reset when the top is not overridden
//   PERF_WIDTH           width of the optional performance counters
package ifetch_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_RESET_VECTOR = 0;
  localparam int unsigned PERF_WIDTH           = 32;

endpackage

// File: rtl/ifetch_perf.sv
// ifetch_perf
// Retired-instruction and decode-stall counters for the fetch stage.
// Both counters wrap naturally at 2^PERF_WIDTH and clear on rst.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   retire       in   an instruction was accepted by decode this cycle
//   stall        in   instr_valid && !instr_ready this cycle
//   perf_retired out  retired instruction count
//   perf_stall   out  stalled cycle count
module ifetch_perf
  import ifetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  retire,
  input  logic                  stall,
  output logic [PERF_WIDTH-1:0] perf_retired,
  output logic [PERF_WIDTH-1:0] perf_stall
);

  logic [PERF_WIDTH-1:0] retired_q, retired_d;
  logic [PERF_WIDTH-1:0] stall_q, stall_d;

  always_comb begin
    retired_d = retired_q + PERF_WIDTH'(retire);
    stall_d   = stall_q + PERF_WIDTH'(stall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_retired = retired_q;
  assign perf_stall   = stall_q;

endmodule

// File: rtl/ifetch.sv
// ifetch
// Instruction fetch stage. Owns the IP register, drives a synchronous-read
// instruction memory and presents {ip, instr} to decode. The next IP comes
// back combinationally from ip_comb (ip_next), so sequential flow, branches
// and vector entries all run at one instruction per cycle.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FILL  | memory read of ip in flight, nothing valid yet (after reset/halt)
// RUN   | instr/ip valid to decode; advance on accept, hold on stall
// HALT  | fetch stopped, waits for halt_req to drop, then refills
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   ip              current IP, feeds ip_comb
//   ip_next         next IP from ip_comb (sequential or branch target)
//   imem_addr       memory read address (combinational)
//   imem_en         memory read enable; rdata valid next cycle, held when 0
//   imem_rdata      memory read data
//   instr           instruction at ip (straight from imem_rdata)
//   instr_valid     instr/ip valid for decode
//   instr_ready     decode accepts instr this cycle
//   halt_req        level; stop at the next instruction boundary
//   halted          high while in HALT
//   vec_valid       level; enter vec_addr at the next instruction boundary
//   vec_addr        vector target
//   vec_ack         one-cycle pulse when the vector is taken
//   vec_ret         return address (ip_next), meaningful with vec_ack
//   perf_retired    retired instruction count (0 unless IFETCH_PERF_EN)
//   perf_stall      cycles with instr_valid && !instr_ready (0 unless IFETCH_PERF_EN)
//
// Build option: define IFETCH_PERF_EN to instantiate the performance
// counters; otherwise both perf outputs are tied to zero.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned              IADDR_WIDTH  = 10,
  parameter int unsigned              INSTR_WIDTH  = 16,
  parameter logic [IADDR_WIDTH-1:0]   RESET_VECTOR = IADDR_WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [IADDR_WIDTH-1:0] ip,
  input  logic [IADDR_WIDTH-1:0] ip_next,
  output logic [IADDR_WIDTH-1:0] imem_addr,
  output logic                   imem_en,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   halt_req,
  output logic                   halted,
  input  logic                   vec_valid,
  input  logic [IADDR_WIDTH-1:0] vec_addr,
  output logic                   vec_ack,
  output logic [IADDR_WIDTH-1:0] vec_ret,
  output logic [PERF_WIDTH-1:0]  perf_retired,
  output logic [PERF_WIDTH-1:0]  perf_stall
);

  state_e                 state_q, state_d;
  logic [IADDR_WIDTH-1:0] ip_q, ip_d;
  logic [IADDR_WIDTH-1:0] target;

  // A vector wins over the ip_comb result; both only matter on accept.
  assign target = vec_valid ? vec_addr : ip_next;

  always_comb begin
    state_d     = state_q;
    ip_d        = ip_q;
    imem_en     = 1'b0;
    imem_addr   = ip_q;
    instr_valid = 1'b0;
    halted      = 1'b0;
    vec_ack     = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        imem_en = 1'b1;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          // Read the next instruction in the same cycle it is decided, so
          // taken branches and vectors cost no bubble.
          ip_d      = target;
          imem_addr = target;
          vec_ack   = vec_valid;
          if (halt_req) begin
            state_d = ST_HALT;
          end else begin
            imem_en = 1'b1;
          end
        end
        // Stalled: imem_en stays low so the memory holds the current word.
      end

      ST_HALT: begin
        halted = 1'b1;
        if (!halt_req) begin
          state_d = ST_FILL;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      ip_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
    end
  end

  assign ip      = ip_q;
  assign instr   = imem_rdata;
  assign vec_ret = ip_next;

`ifdef IFETCH_PERF_EN
  logic accept;
  logic stall;

  assign accept = instr_valid && instr_ready;
  assign stall  = instr_valid && !instr_ready;

  ifetch_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .retire       (accept),
    .stall        (stall),
    .perf_retired (perf_retired),
    .perf_stall   (perf_stall)
  );
`else
  assign perf_retired = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch
// Bench for the fetch stage: a sync-read memory model whose word at address
// a is memfn(a), an ip_comb model (ip+1 with one optional branch), and a
// queue of expected IPs that is consumed as decode accepts instructions.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  ip, ip_next, imem_addr, vec_addr, vec_ret;
  logic        imem_en, instr_valid, instr_ready, halt_req, halted, vec_valid, vec_ack;
  logic [15:0] imem_rdata, instr;
  logic [31:0] perf_retired, perf_stall;

  logic        br_en = 1'b0;
  logic [9:0]  br_at = '0, br_tgt = '0;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  e, e_nxt;

  always #5 clk = ~clk;

  function automatic logic [15:0] memfn(input logic [9:0] a);
    return {a[5:0], a} ^ 16'hC3A5;
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= memfn(imem_addr);
  end

  assign ip_next = (br_en && ip == br_at) ? br_tgt : ip + 10'd1;

  ifetch #(.IADDR_WIDTH(10), .INSTR_WIDTH(16), .RESET_VECTOR(10'd0)) dut (
    .clk(clk), .rst(rst), .ip(ip), .ip_next(ip_next),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .halt_req(halt_req), .halted(halted), .vec_valid(vec_valid), .vec_addr(vec_addr),
    .vec_ack(vec_ack), .vec_ret(vec_ret), .perf_retired(perf_retired), .perf_stall(perf_stall)
  );

`ifdef IFETCH_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  // Reset and sit through the FILL cycle; next negedge sees RUN at ip 0.
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; instr_ready = 1'b0; halt_req = 1'b0; vec_valid = 1'b0; br_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Accept n sequential instructions; afterwards ip == n (with no branch).
  task automatic advance(input int n);
    repeat (n) begin
      @(negedge clk);
      instr_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    instr_ready = 1'b0; halt_req = 1'b0; vec_valid = 1'b0; vec_addr = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %b want 0", halted); end
    n_cmp++; if (vec_ack !== 1'b0) begin n_bad++; $display("FAIL rst_vec_ack: got %b want 0", vec_ack); end
    n_cmp++; if (ip !== 10'd0) begin n_bad++; $display("FAIL rst_ip: got %h want 000", ip); end
    n_cmp++; if (perf_retired !== 32'd0 || perf_stall !== 32'd0) begin n_bad++; $display("FAIL rst_perf: got %0d/%0d want 0/0", perf_retired, perf_stall); end
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_en !== 1'b1 || imem_addr !== 10'd0) begin n_bad++; $display("FAIL fill_read: got en=%b addr=%h want en=1 addr=000", imem_en, imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL fill_valid: got %b want 0", instr_valid); end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 5; k++) exp_q.push_back(10'(k));
    for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      instr_ready = 1'b1;
      #1;
      n_cmp++;
      if (instr_valid !== 1'b1) begin
        n_bad++; $display("FAIL seq_valid: got %b want 1 (cycle %0d)", instr_valid, c);
      end else begin
        e = exp_q.pop_front();
        n_cmp++; if (ip !== e) begin n_bad++; $display("FAIL seq_ip: got %h want %h", ip, e); end
        n_cmp++; if (instr !== memfn(e)) begin n_bad++; $display("FAIL seq_instr: got %h want %h", instr, memfn(e)); end
        n_cmp++; if (imem_addr !== e + 10'd1 || imem_en !== 1'b1) begin n_bad++; $display("FAIL seq_fetch: got addr=%h en=%b want addr=%h en=1", imem_addr, imem_en, e + 10'd1); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL seq_timeout: got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_branch();
    br_at = 10'd5; br_tgt = 10'h3F0;
    exp_q.push_back(10'd5); exp_q.push_back(10'h3F0); exp_q.push_back(10'h3F1);
    for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      br_en = 1'b1; instr_ready = 1'b1;
      #1;
      n_cmp++;
      if (instr_valid !== 1'b1) begin
        n_bad++; $display("FAIL br_bubble: got valid=%b want 1 (cycle %0d)", instr_valid, c);
      end else begin
        e = exp_q.pop_front();
        e_nxt = (e == br_at) ? br_tgt : e + 10'd1;
        n_cmp++; if (ip !== e) begin n_bad++; $display("FAIL br_ip: got %h want %h", ip, e); end
        n_cmp++; if (instr !== memfn(e)) begin n_bad++; $display("FAIL br_instr: got %h want %h", instr, memfn(e)); end
        n_cmp++; if (imem_addr !== e_nxt) begin n_bad++; $display("FAIL br_addr: got %h want %h", imem_addr, e_nxt); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL br_timeout: got %0d left want 0", exp_q.size()); exp_q.delete(); end
    br_en = 1'b0;
  endtask

  task automatic test_stall();
    reset_dut();
    advance(7);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      instr_ready = 1'b0;
      #1;
      n_cmp++; if (ip !== 10'd7 || instr_valid !== 1'b1) begin n_bad++; $display("FAIL stall_ip: got ip=%h valid=%b want ip=007 valid=1", ip, instr_valid); end
      n_cmp++; if (instr !== memfn(10'd7)) begin n_bad++; $display("FAIL stall_instr: got %h want %h", instr, memfn(10'd7)); end
      n_cmp++; if (imem_en !== 1'b0 || imem_addr !== 10'd7) begin n_bad++; $display("FAIL stall_mem: got en=%b addr=%h want en=0 addr=007", imem_en, imem_addr); end
    end
    @(negedge clk);
    instr_ready = 1'b1;
    #1;
    n_cmp++; if (imem_en !== 1'b1 || imem_addr !== 10'd8) begin n_bad++; $display("FAIL stall_release: got en=%b addr=%h want en=1 addr=008", imem_en, imem_addr); end
    n_cmp++; if (perf_stall !== (PERF_ON ? 32'd3 : 32'd0)) begin n_bad++; $display("FAIL perf_stall: got %0d want %0d", perf_stall, PERF_ON ? 3 : 0); end
    n_cmp++; if (perf_retired !== (PERF_ON ? 32'd7 : 32'd0)) begin n_bad++; $display("FAIL perf_retired: got %0d want %0d", perf_retired, PERF_ON ? 7 : 0); end
    @(negedge clk);
    #1;
    n_cmp++; if (ip !== 10'd8 || instr !== memfn(10'd8)) begin n_bad++; $display("FAIL stall_next: got ip=%h instr=%h want ip=008 instr=%h", ip, instr, memfn(10'd8)); end
  endtask

  task automatic test_halt();
    reset_dut();
    advance(4);
    @(negedge clk);
    halt_req = 1'b1; instr_ready = 1'b1;
    #1;
    n_cmp++; if (ip !== 10'd4 || imem_en !== 1'b0 || imem_addr !== 10'd5) begin n_bad++; $display("FAIL halt_accept: got ip=%h en=%b addr=%h want ip=004 en=0 addr=005", ip, imem_en, imem_addr); end
    @(negedge clk);
    vec_valid = 1'b1; vec_addr = 10'h100;
    #1;
    n_cmp++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL halt_state: got halted=%b valid=%b want 1/0", halted, instr_valid); end
    n_cmp++; if (ip !== 10'd5 || imem_en !== 1'b0) begin n_bad++; $display("FAIL halt_ip: got ip=%h en=%b want ip=005 en=0", ip, imem_en); end
    n_cmp++; if (vec_ack !== 1'b0) begin n_bad++; $display("FAIL halt_vec_ignored: got %b want 0", vec_ack); end
    @(negedge clk);
    halt_req = 1'b0; vec_valid = 1'b0;
    #1;
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_hold: got %b want 1", halted); end
    @(negedge clk);
    #1;
    n_cmp++; if (halted !== 1'b0 || instr_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 10'd5) begin n_bad++; $display("FAIL resume_fill: got halted=%b valid=%b en=%b addr=%h want 0/0/1/005", halted, instr_valid, imem_en, imem_addr); end
    @(negedge clk);
    #1;
    n_cmp++; if (instr_valid !== 1'b1 || ip !== 10'd5 || instr !== memfn(10'd5)) begin n_bad++; $display("FAIL resume_instr: got valid=%b ip=%h instr=%h want 1/005/%h", instr_valid, ip, instr, memfn(10'd5)); end
  endtask

  task automatic test_vector();
    reset_dut();
    advance(9);
    @(negedge clk);
    instr_ready = 1'b0; vec_valid = 1'b1; vec_addr = 10'h200;
    #1;
    n_cmp++; if (vec_ack !== 1'b0 || ip !== 10'd9) begin n_bad++; $display("FAIL vec_deferred: got ack=%b ip=%h want 0/009", vec_ack, ip); end
    @(negedge clk);
    instr_ready = 1'b1;
    #1;
    n_cmp++; if (vec_ack !== 1'b1) begin n_bad++; $display("FAIL vec_ack: got %b want 1", vec_ack); end
    n_cmp++; if (vec_ret !== 10'd10) begin n_bad++; $display("FAIL vec_ret: got %h want 00a", vec_ret); end
    n_cmp++; if (imem_addr !== 10'h200 || imem_en !== 1'b1) begin n_bad++; $display("FAIL vec_fetch: got addr=%h en=%b want 200/1", imem_addr, imem_en); end
    @(negedge clk);
    vec_valid = 1'b0;
    #1;
    n_cmp++; if (vec_ack !== 1'b0) begin n_bad++; $display("FAIL vec_pulse: got %b want 0", vec_ack); end
    n_cmp++; if (ip !== 10'h200 || instr_valid !== 1'b1 || instr !== memfn(10'h200)) begin n_bad++; $display("FAIL vec_entry: got ip=%h valid=%b instr=%h want 200/1/%h", ip, instr_valid, instr, memfn(10'h200)); end
  endtask

  task automatic test_vec_halt();
    reset_dut();
    advance(3);
    @(negedge clk);
    instr_ready = 1'b1; halt_req = 1'b1; vec_valid = 1'b1; vec_addr = 10'h123;
    #1;
    n_cmp++; if (vec_ack !== 1'b1 || vec_ret !== 10'd4 || imem_en !== 1'b0) begin n_bad++; $display("FAIL vh_accept: got ack=%b ret=%h en=%b want 1/004/0", vec_ack, vec_ret, imem_en); end
    @(negedge clk);
    vec_valid = 1'b0;
    #1;
    n_cmp++; if (halted !== 1'b1 || ip !== 10'h123) begin n_bad++; $display("FAIL vh_halted: got halted=%b ip=%h want 1/123", halted, ip); end
    halt_req = 1'b0;
  endtask

  task automatic test_wrap();
    reset_dut();
    br_en = 1'b1; br_at = 10'd0; br_tgt = 10'h3FE;
    advance(1);
    @(negedge clk);
    br_en = 1'b0;
    exp_q.push_back(10'h3FE); exp_q.push_back(10'h3FF); exp_q.push_back(10'h000); exp_q.push_back(10'h001);
    for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
      if (c != 0) @(negedge clk);
      instr_ready = 1'b1;
      #1;
      n_cmp++;
      if (instr_valid !== 1'b1) begin
        n_bad++; $display("FAIL wrap_valid: got %b want 1 (cycle %0d)", instr_valid, c);
      end else begin
        e = exp_q.pop_front();
        n_cmp++; if (ip !== e || instr !== memfn(e)) begin n_bad++; $display("FAIL wrap_ip: got ip=%h instr=%h want %h/%h", ip, instr, e, memfn(e)); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL wrap_timeout: got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_in_stall();
    reset_dut();
    br_en = 1'b1; br_at = 10'd0; br_tgt = 10'h3FF;
    advance(1);
    @(negedge clk);
    br_en = 1'b0; instr_ready = 1'b0;
    #1;
    n_cmp++; if (ip !== 10'h3FF || instr_valid !== 1'b1 || imem_en !== 1'b0) begin n_bad++; $display("FAIL rs_stall: got ip=%h valid=%b en=%b want 3ff/1/0", ip, instr_valid, imem_en); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (ip !== 10'd0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL rs_fill: got ip=%h valid=%b want 000/0", ip, instr_valid); end
    n_cmp++; if (imem_en !== 1'b1 || imem_addr !== 10'd0) begin n_bad++; $display("FAIL rs_read: got en=%b addr=%h want 1/000", imem_en, imem_addr); end
    n_cmp++; if (perf_retired !== 32'd0 || perf_stall !== 32'd0) begin n_bad++; $display("FAIL rs_perf: got %0d/%0d want 0/0", perf_retired, perf_stall); end
    @(negedge clk);
    #1;
    n_cmp++; if (instr_valid !== 1'b1 || ip !== 10'd0 || instr !== memfn(10'd0)) begin n_bad++; $display("FAIL rs_first: got valid=%b ip=%h instr=%h want 1/000/%h", instr_valid, ip, instr, memfn(10'd0)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_halt();
    test_vector();
    test_vec_halt();
    test_wrap();
    test_reset_in_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
